// File: rtl/commit_trace_buf.sv
// Writeback commit-record tap: captures retired instructions into a FWFT FIFO
// drained by a valid/ready consumer, with commit-aligned stop, counters and overflow tracking.
module commit_trace_buf #(
    parameter int PC_WD    = 64,
    parameter int INST_WD  = 32,
    parameter int DATA_WD  = 64,
    parameter int ADDR_WD  = 5,
    parameter int DEPTH    = 8,
    parameter int STOP_DLY = 4,
    parameter int CNT_WD   = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      trace_en,
    input  logic                      in_valid,
    input  logic [PC_WD-1:0]          in_pc,
    input  logic [INST_WD-1:0]        in_inst,
    input  logic                      in_exp,
    input  logic                      in_mret,
    input  logic                      in_rf_wen,
    input  logic [ADDR_WD-1:0]        in_rf_wnum,
    input  logic [DATA_WD-1:0]        in_rf_wdata,
    input  logic                      stop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_WD-1:0]          out_pc,
    output logic [INST_WD-1:0]        out_inst,
    output logic                      out_exp,
    output logic                      out_mret,
    output logic                      out_rf_wen,
    output logic [ADDR_WD-1:0]        out_rf_wnum,
    output logic [DATA_WD-1:0]        out_rf_wdata,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_WD-1:0]         commit_cnt,
    output logic [CNT_WD-1:0]         drop_cnt,
    output logic                      overflow,
    output logic                      halt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = PC_WD + INST_WD + 3 + ADDR_WD + DATA_WD;

    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_WD-1:0] CNT_ONE  = CNT_WD'(1);

    logic [REC_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [CNT_WD-1:0] r_commit_cnt;
    logic [CNT_WD-1:0] r_drop_cnt;
    logic              r_overflow;
    logic              r_halt;
    logic              r_stop_seen;

    logic              w_stop_last;
    logic              w_acc;
    logic              w_push_req;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [REC_W-1:0]  w_in_rec;
    logic [REC_W-1:0]  w_head;

    // Stop alignment: decode-aligned stop delayed to line up with writeback
    generate
        if (STOP_DLY == 0) begin : g_stop_direct
            assign w_stop_last = stop;
        end else begin : g_stop_pipe
            logic [STOP_DLY-1:0] r_stop_p;
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_stop_p <= '0;
                end else begin
                    r_stop_p[0] <= stop;
                    for (int i = 1; i < STOP_DLY; i++) begin
                        r_stop_p[i] <= r_stop_p[i-1];
                    end
                end
            end
            assign w_stop_last = r_stop_p[STOP_DLY-1];
        end
    endgenerate

    assign w_acc      = in_valid & ~r_stop_seen;
    assign w_push_req = w_acc & trace_en;
    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    assign w_pop      = ~w_empty & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    assign w_in_rec = {in_pc, in_inst, in_exp, in_mret, in_rf_wen, in_rf_wnum, in_rf_wdata};
    assign w_head   = r_mem[r_rd_ptr];

    assign out_valid = ~w_empty;
    assign {out_pc, out_inst, out_exp, out_mret, out_rf_wen, out_rf_wnum, out_rf_wdata} = w_head;

    assign level      = r_level;
    assign commit_cnt = r_commit_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign overflow   = r_overflow;
    assign halt       = r_halt;

    // Record storage carries no reset; validity comes from r_level alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_commit_cnt <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_halt       <= 1'b0;
            r_stop_seen  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_acc) begin
                r_commit_cnt <= r_commit_cnt + CNT_ONE;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
                r_overflow <= 1'b1;
            end
            if (w_stop_last) begin
                r_stop_seen <= 1'b1;
            end
            // Halt waits until every buffered record has been consumed
            if (r_stop_seen & w_empty & ~w_push) begin
                r_halt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Bench for commit_trace_buf: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_commit_trace_buf;

    localparam int PC_WD    = 64;
    localparam int INST_WD  = 32;
    localparam int DATA_WD  = 64;
    localparam int ADDR_WD  = 5;
    localparam int DEPTH    = 8;
    localparam int STOP_DLY = 4;
    localparam int CNT_WD   = 64;
    localparam int LVL_W    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [PC_WD-1:0]   pc;
        logic [INST_WD-1:0] inst;
        logic               exp;
        logic               mret;
        logic               wen;
        logic [ADDR_WD-1:0] wnum;
        logic [DATA_WD-1:0] wdata;
    } rec_t;

    logic               clk = 1'b0;
    logic               resetn;
    logic               trace_en;
    logic               in_valid;
    logic [PC_WD-1:0]   in_pc;
    logic [INST_WD-1:0] in_inst;
    logic               in_exp;
    logic               in_mret;
    logic               in_rf_wen;
    logic [ADDR_WD-1:0] in_rf_wnum;
    logic [DATA_WD-1:0] in_rf_wdata;
    logic               stop;
    logic               out_valid;
    logic               out_ready;
    logic [PC_WD-1:0]   out_pc;
    logic [INST_WD-1:0] out_inst;
    logic               out_exp;
    logic               out_mret;
    logic               out_rf_wen;
    logic [ADDR_WD-1:0] out_rf_wnum;
    logic [DATA_WD-1:0] out_rf_wdata;
    logic [LVL_W-1:0]   level;
    logic [CNT_WD-1:0]  commit_cnt;
    logic [CNT_WD-1:0]  drop_cnt;
    logic               overflow;
    logic               halt;

    commit_trace_buf #(
        .PC_WD(PC_WD), .INST_WD(INST_WD), .DATA_WD(DATA_WD), .ADDR_WD(ADDR_WD),
        .DEPTH(DEPTH), .STOP_DLY(STOP_DLY), .CNT_WD(CNT_WD)
    ) dut (
        .clk(clk), .resetn(resetn), .trace_en(trace_en), .in_valid(in_valid),
        .in_pc(in_pc), .in_inst(in_inst), .in_exp(in_exp), .in_mret(in_mret),
        .in_rf_wen(in_rf_wen), .in_rf_wnum(in_rf_wnum), .in_rf_wdata(in_rf_wdata),
        .stop(stop), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_exp(out_exp), .out_mret(out_mret),
        .out_rf_wen(out_rf_wen), .out_rf_wnum(out_rf_wnum), .out_rf_wdata(out_rf_wdata),
        .level(level), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt),
        .overflow(overflow), .halt(halt)
    );

    always #5 clk = ~clk;

    // Reference model state
    rec_t        m_q[$];
    bit          m_hist[$];
    longint      m_cnt;
    longint      m_drop;
    bit          m_ovf;
    bit          m_halt;
    bit          m_seen;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        r.pc    = {$urandom, $urandom};
        r.inst  = $urandom;
        r.exp   = 1'($urandom_range(0, 1));
        r.mret  = 1'($urandom_range(0, 1));
        r.wen   = 1'($urandom_range(0, 1));
        r.wnum  = 5'($urandom_range(0, 31));
        r.wdata = {$urandom, $urandom};
        return r;
    endfunction

    function automatic rec_t pc_rec(input logic [63:0] pc);
        rec_t r;
        r = rand_rec();
        r.pc = pc;
        return r;
    endfunction

    function automatic void model_step(input bit rn, input bit te, input bit v,
                                       input rec_t r, input bit st, input bit rdy);
        bit last, acc, pop, push_req, pushed, halt_n;
        if (!rn) begin
            m_q.delete();
            m_hist.delete();
            for (int i = 0; i < STOP_DLY; i++) m_hist.push_back(1'b0);
            m_cnt = 0; m_drop = 0; m_ovf = 0; m_halt = 0; m_seen = 0;
            return;
        end
        m_hist.push_back(st);
        last     = m_hist.pop_front();
        acc      = v && !m_seen;
        pop      = (m_q.size() != 0) && rdy;
        push_req = acc && te;
        pushed   = push_req && ((m_q.size() < DEPTH) || pop);
        halt_n   = m_halt || (m_seen && (m_q.size() == 0) && !pushed);
        if (acc) m_cnt++;
        if (pop) void'(m_q.pop_front());
        if (pushed) m_q.push_back(r);
        else if (push_req) begin
            m_drop++;
            m_ovf = 1;
        end
        m_halt = halt_n;
        if (last) m_seen = 1;
    endfunction

    task automatic check_all();
        check_eq("level", 64'(level), 64'(m_q.size()));
        check_eq("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        check_eq("commit_cnt", commit_cnt, m_cnt);
        check_eq("drop_cnt", drop_cnt, m_drop);
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("halt", 64'(halt), 64'(m_halt));
        if (m_q.size() != 0) begin
            check_eq("head_pc", out_pc, m_q[0].pc);
            check_eq("head_inst", 64'(out_inst), 64'(m_q[0].inst));
            check_eq("head_flags", 64'({out_exp, out_mret, out_rf_wen}),
                     64'({m_q[0].exp, m_q[0].mret, m_q[0].wen}));
            check_eq("head_wnum", 64'(out_rf_wnum), 64'(m_q[0].wnum));
            check_eq("head_wdata", out_rf_wdata, m_q[0].wdata);
        end
    endtask

    // Called at a negedge: drive, advance model, clock, then compare
    task automatic cycle(input bit rn, input bit te, input bit v, input rec_t r,
                         input bit st, input bit rdy);
        resetn      = rn;
        trace_en    = te;
        in_valid    = v;
        in_pc       = r.pc;
        in_inst     = r.inst;
        in_exp      = r.exp;
        in_mret     = r.mret;
        in_rf_wen   = r.wen;
        in_rf_wnum  = r.wnum;
        in_rf_wdata = r.wdata;
        stop        = st;
        out_ready   = rdy;
        model_step(rn, te, v, r, st, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b1, 1'b0, rand_rec(), 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] base;
        logic [63:0] base2;
        resetn = 1'b0; trace_en = 1'b0; in_valid = 1'b0; stop = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0; in_exp = 1'b0; in_mret = 1'b0; in_rf_wen = 1'b0;
        in_rf_wnum = '0; in_rf_wdata = '0;
        base  = 64'h8000_0000;
        base2 = 64'h9000_0000;
        @(negedge clk);

        // Basic FWFT behaviour
        do_reset();
        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        cycle(1, 1, 1, pc_rec(base), 0, 0);
        check_eq("first_head", out_pc, base);
        cycle(1, 1, 1, pc_rec(base + 4), 0, 0);
        cycle(1, 1, 1, pc_rec(base + 8), 0, 0);
        check_eq("three_level", 64'(level), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq("drain_order", out_pc, base + 64'(4 * i));
            cycle(1, 1, 0, rand_rec(), 0, 1);
        end
        check_eq("drained_valid", 64'(out_valid), 64'd0);
        check_eq("three_cnt", commit_cnt, 64'd3);

        // Overflow, then full with simultaneous push/pop
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1, 1, 1, pc_rec(base + 64'(4 * i)), 0, 0);
        check_eq("ovf_level", 64'(level), 64'd8);
        check_eq("ovf_drop", drop_cnt, 64'd2);
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq("pp_head", out_pc, base + 64'(4 * i));
            cycle(1, 1, 1, pc_rec(base2 + 64'(4 * i)), 0, 1);
        end
        check_eq("pp_level", 64'(level), 64'd8);
        check_eq("pp_drop", drop_cnt, 64'd2);
        for (int i = 0; i < 8; i++) begin
            check_eq("pp_drain", out_pc, (i < 3) ? base + 64'(4 * (i + 5)) : base2 + 64'(4 * (i - 3)));
            cycle(1, 1, 0, rand_rec(), 0, 1);
        end
        check_eq("pp_empty", 64'(out_valid), 64'd0);

        // Count-only mode
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 1, rand_rec(), 0, 0);
            check_eq("noTrace_valid", 64'(out_valid), 64'd0);
        end
        check_eq("noTrace_cnt", commit_cnt, 64'd4);
        check_eq("noTrace_level", 64'(level), 64'd0);

        // Stop alignment and halt timing
        do_reset();
        cycle(1, 1, 1, rand_rec(), 0, 1);
        cycle(1, 1, 1, rand_rec(), 0, 1);
        cycle(1, 1, 1, rand_rec(), 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, rand_rec(), 0, 1);
        check_eq("stop_valid_last", 64'(out_valid), 64'd1);
        cycle(1, 1, 1, rand_rec(), 0, 1);
        check_eq("stop_halt_early", 64'(halt), 64'd0);
        cycle(1, 1, 1, rand_rec(), 0, 1);
        check_eq("stop_halt", 64'(halt), 64'd1);
        cycle(1, 1, 1, rand_rec(), 0, 1);
        cycle(1, 1, 1, rand_rec(), 0, 1);
        check_eq("stop_cnt", commit_cnt, 64'd7);

        // Reset mid-operation with overflow and buffered records
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1, 1, 1, rand_rec(), 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, rand_rec(), 0, 1);
        check_eq("pre_rst_level", 64'(level), 64'd5);
        check_eq("pre_rst_ovf", 64'(overflow), 64'd1);
        do_reset();
        check_eq("mid_rst_level", 64'(level), 64'd0);
        check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_ovf", 64'(overflow), 64'd0);
        check_eq("mid_rst_cnt", commit_cnt | drop_cnt, 64'd0);
        check_eq("mid_rst_halt", 64'(halt), 64'd0);

        // Randomized traffic
        for (int ep = 0; ep < 30; ep++) begin
            int rdy_pct;
            int len;
            rdy_pct = $urandom_range(10, 95);
            len     = $urandom_range(100, 250);
            do_reset();
            for (int c = 0; c < len; c++) begin
                bit rn, te, v, st, rdy;
                rn  = ($urandom_range(0, 299) != 0);
                te  = ($urandom_range(0, 9) != 0);
                v   = ($urandom_range(0, 99) < 70);
                st  = ($urandom_range(0, 149) == 0);
                rdy = ($urandom_range(0, 99) < rdy_pct);
                cycle(rn, te, v, rand_rec(), st, rdy);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
